// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and defaults for the two-port memory arbiter.
//               Holds the FSM state encoding, the owner encoding and the
//               default fetch-starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_I = 2'd1,
        REQ_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Which requester owns the current transaction
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Maximum consecutive D-grants while a fetch is waiting
    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_counter
// Description : Saturating count of consecutive D-grants made while the
//               I-port was waiting. at_limit tells the arbiter that the next
//               contested grant must go to the I-port.
// Ports       : clk, reset (sync, active-high)
//               d_grant   - a D-grant is being made this cycle
//               i_grant   - an I-grant is being made this cycle
//               i_waiting - i_req was high when the grant was made
//               at_limit  - streak has reached STARVE_LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic d_grant,
    input  logic i_grant,
    input  logic i_waiting,
    output logic at_limit
);

    localparam int                c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_streak_q;
    logic [c_cnt_w-1:0] w_streak_d;

    always_comb begin
        w_streak_d = r_streak_q;
        if (i_grant) begin
            w_streak_d = '0;
        end else if (d_grant) begin
            // Only a D-grant that actually made a fetch wait counts toward
            // starvation; an uncontested one restarts the streak.
            if (i_waiting) begin
                if (r_streak_q != c_limit) begin
                    w_streak_d = r_streak_q + c_cnt_w'(1);
                end
            end else begin
                w_streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak_q <= '0;
        end else begin
            r_streak_q <= w_streak_d;
        end
    end

    assign at_limit = (r_streak_q == c_limit);

endmodule : arb_starve_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one variable-latency memory between the instruction
//               fetch port (I) and the data port (D). D has priority; a
//               starvation counter forces an I-grant after STARVE_LIMIT
//               contested D-grants. One transaction at a time:
//               IDLE -> REQ_x -> RESP -> IDLE.
// Ports       : clk, reset (sync, active-high)
//               i_req/i_addr -> i_ready/i_rdata          fetch port
//               d_req/d_write/d_addr/d_wdata
//                            -> d_ready/d_rdata          data port
//               mem_req/mem_write/mem_addr/mem_wdata
//                            <- mem_ready/mem_rdata      backing memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state_q, w_state_d;
    owner_t            r_owner_q, w_owner_d;
    logic              r_write_q, w_write_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [DATA_W-1:0] r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0] r_resp_q,  w_resp_d;

    logic w_idle;
    logic w_at_limit;
    logic w_d_grant;
    logic w_i_grant;

    // Port requests are only looked at in IDLE.
    assign w_idle    = (r_state_q == IDLE);
    assign w_d_grant = w_idle && d_req && (!i_req || !w_at_limit);
    assign w_i_grant = w_idle && i_req && !w_d_grant;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .d_grant   (w_d_grant),
        .i_grant   (w_i_grant),
        .i_waiting (i_req),
        .at_limit  (w_at_limit)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_owner_d = r_owner_q;
        w_write_d = r_write_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_resp_d  = r_resp_q;
        case (r_state_q)
            IDLE: begin
                if (w_d_grant) begin
                    w_state_d = REQ_D;
                    w_owner_d = OWN_D;
                    w_write_d = d_write;
                    w_addr_d  = d_addr;
                    w_wdata_d = d_wdata;
                end else if (w_i_grant) begin
                    w_state_d = REQ_I;
                    w_owner_d = OWN_I;
                    w_write_d = 1'b0;
                    w_addr_d  = i_addr;
                    w_wdata_d = '0;
                end
            end
            REQ_I, REQ_D: begin
                if (mem_ready) begin
                    // Stores return zero so d_rdata never shows stale data.
                    w_resp_d  = r_write_q ? '0 : mem_rdata;
                    w_state_d = RESP;
                end
            end
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_owner_q <= OWN_I;
            r_write_q <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_resp_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_write_q <= w_write_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_resp_q  <= w_resp_d;
        end
    end

    // All outputs are decoded purely from registers.
    assign mem_req   = (r_state_q == REQ_I) || (r_state_q == REQ_D);
    assign mem_write = r_write_q;
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign i_ready   = (r_state_q == RESP) && (r_owner_q == OWN_I);
    assign d_ready   = (r_state_q == RESP) && (r_owner_q == OWN_D);
    assign i_rdata   = (r_owner_q == OWN_I) ? r_resp_q : '0;
    assign d_rdata   = (r_owner_q == OWN_D) ? r_resp_q : '0;

endmodule : mem_arbiter
`default_nettype wire
